elevator_call_scheduler: RTL and testbench

- Latches floor call buttons and selects the next target floor for the elevator sequencing FSM using SCAN ordering: keep serving in the current direction, reverse only when no calls remain ahead.
- Sits between the button inputs and the elevator controller.
- The controller reads target_floor/target_valid and compares them against its floor counter.
- The controller pulses arrive when the car stops and the door cycle completes.

---
 rtl/elevator_call_scheduler_if.sv | 28 ++
 rtl/elevator_call_scheduler.sv | 146 ++++++++++++++
 tb/tb_elevator_call_scheduler.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/elevator_call_scheduler_if.sv
// Signal bundle between the call buttons / elevator controller (master) and the
// SCAN call scheduler (slave).
interface elevator_call_scheduler_if #(
    parameter int FLOORS = 8,
    parameter int FW     = 3
);
    // No ready/valid pair here: arrive is a single-cycle strobe from the
    // controller, and target_floor is meaningful only while target_valid is high.
    logic [FLOORS-1:0] call_btn;
    logic [FW-1:0]     cur_floor;
    logic              arrive;
    logic [FW-1:0]     target_floor;
    logic              target_valid;
    logic              dir_up;
    logic [FLOORS-1:0] req_pending;
    logic              idle;
    logic [1:0]        state_dbg;

    modport master (
        output call_btn, cur_floor, arrive,
        input  target_floor, target_valid, dir_up, req_pending, idle, state_dbg
    );

    modport slave (
        input  call_btn, cur_floor, arrive,
        output target_floor, target_valid, dir_up, req_pending, idle, state_dbg
    );
endinterface

// File: rtl/elevator_call_scheduler.sv
// Latches floor calls and picks the next target floor with SCAN ordering:
// keep going in the current direction, reverse only when nothing is left ahead.
module elevator_call_scheduler #(
    parameter int FLOORS = 8,
    parameter int FW     = 3
) (
    input logic                    clk,
    input logic                    reset,
    elevator_call_scheduler_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SCAN_UP   = 2'd1,
        SCAN_DOWN = 2'd2
    } state_t;

    state_t            state;
    logic [FLOORS-1:0] req_q;
    logic [FLOORS-1:0] hist_q;
    logic [FW-1:0]     tgt_q;
    logic              vld_q;
    logic              dir_q;
    logic              idle_q;

    logic [FLOORS-1:0] clr_mask;
    logic [FLOORS-1:0] req_nxt;
    logic              in_range;
    logic              here;
    logic              above_found;
    logic              below_found;
    logic [FW-1:0]     above_idx;
    logic [FW-1:0]     below_idx;

    assign in_range = (int'(bus.cur_floor) < FLOORS);

    // Clear wins over a new press on the floor just served.
    always_comb begin
        clr_mask = '0;
        if (bus.arrive && in_range) clr_mask[bus.cur_floor] = 1'b1;
        req_nxt = (req_q | (bus.call_btn & ~hist_q)) & ~clr_mask;
    end

    // Nearest pending floor on each side; the loop direction leaves the closest hit.
    always_comb begin
        here        = in_range ? req_q[bus.cur_floor] : 1'b0;
        above_found = 1'b0;
        above_idx   = '0;
        below_found = 1'b0;
        below_idx   = '0;
        for (int i = FLOORS - 1; i >= 0; i--) begin
            if (req_q[i] && (i > int'(bus.cur_floor))) begin
                above_found = 1'b1;
                above_idx   = FW'(i);
            end
        end
        for (int i = 0; i < FLOORS; i++) begin
            if (req_q[i] && (i < int'(bus.cur_floor))) begin
                below_found = 1'b1;
                below_idx   = FW'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            req_q  <= '0;
            hist_q <= '0;
            tgt_q  <= '0;
            vld_q  <= 1'b0;
            dir_q  <= 1'b1;
            idle_q <= 1'b1;
        end else begin
            hist_q <= bus.call_btn;
            req_q  <= req_nxt;
            case (state)
                IDLE: begin
                    if (here) begin
                        tgt_q  <= bus.cur_floor;
                        vld_q  <= 1'b1;
                        idle_q <= (req_nxt == '0);
                    end else if (above_found) begin
                        state  <= SCAN_UP;
                        dir_q  <= 1'b1;
                        tgt_q  <= above_idx;
                        vld_q  <= 1'b1;
                        idle_q <= 1'b0;
                    end else if (below_found) begin
                        state  <= SCAN_DOWN;
                        dir_q  <= 1'b0;
                        tgt_q  <= below_idx;
                        vld_q  <= 1'b1;
                        idle_q <= 1'b0;
                    end else begin
                        vld_q  <= 1'b0;
                        idle_q <= (req_nxt == '0);
                    end
                end
                SCAN_UP: begin
                    if (above_found) begin
                        tgt_q  <= above_idx;
                        vld_q  <= 1'b1;
                        idle_q <= 1'b0;
                    end else if (below_found || here) begin
                        // Reversal cycle deliberately drops valid for one cycle.
                        state  <= SCAN_DOWN;
                        dir_q  <= 1'b0;
                        vld_q  <= 1'b0;
                        idle_q <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        vld_q  <= 1'b0;
                        idle_q <= (req_nxt == '0);
                    end
                end
                SCAN_DOWN: begin
                    if (below_found) begin
                        tgt_q  <= below_idx;
                        vld_q  <= 1'b1;
                        idle_q <= 1'b0;
                    end else if (above_found || here) begin
                        state  <= SCAN_UP;
                        dir_q  <= 1'b1;
                        vld_q  <= 1'b0;
                        idle_q <= 1'b0;
                    end else begin
                        state  <= IDLE;
                        vld_q  <= 1'b0;
                        idle_q <= (req_nxt == '0);
                    end
                end
                default: begin
                    state <= IDLE;
                    vld_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.target_floor = tgt_q;
    assign bus.target_valid = vld_q;
    assign bus.dir_up       = dir_q;
    assign bus.req_pending  = req_q;
    assign bus.idle         = idle_q;
    assign bus.state_dbg    = state;
endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed bench for the SCAN call scheduler: a per-cycle vector table plus
// hand-written sequences for held buttons, retargeting and async reset.
module tb_elevator_call_scheduler;
    localparam int FLOORS = 8;
    localparam int FW     = 3;
    localparam int NVEC   = 17;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    elevator_call_scheduler_if #(.FLOORS(FLOORS), .FW(FW)) bus ();

    elevator_call_scheduler #(.FLOORS(FLOORS), .FW(FW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] btn;
        logic [2:0] cur;
        logic       arr;
        logic [7:0] req;
        logic [2:0] tgt;
        logic       vld;
        logic       dir;
        logic       idl;
    } vec_t;

    vec_t vecs[NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic drive(input logic [7:0] btn, input logic [2:0] cur, input logic arr);
        bus.call_btn  = btn;
        bus.cur_floor = cur;
        bus.arrive    = arr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        drive(8'h00, 3'd2, 1'b0);

        //                btn    cur  arr  req    tgt  vld  dir  idle
        vecs[0]  = '{8'h00, 3'd2, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[1]  = '{8'h21, 3'd2, 1'b0, 8'h21, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[2]  = '{8'h00, 3'd2, 1'b0, 8'h21, 3'd5, 1'b1, 1'b1, 1'b0};
        vecs[3]  = '{8'h00, 3'd2, 1'b0, 8'h21, 3'd5, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{8'h00, 3'd5, 1'b1, 8'h01, 3'd5, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{8'h00, 3'd5, 1'b0, 8'h01, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{8'h00, 3'd0, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[7]  = '{8'h00, 3'd0, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[8]  = '{8'h02, 3'd1, 1'b1, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[9]  = '{8'h02, 3'd1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{8'h00, 3'd1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{8'h02, 3'd1, 1'b0, 8'h02, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{8'h00, 3'd1, 1'b0, 8'h02, 3'd1, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{8'h00, 3'd1, 1'b1, 8'h00, 3'd1, 1'b1, 1'b1, 1'b1};
        vecs[14] = '{8'h00, 3'd1, 1'b0, 8'h00, 3'd1, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{8'h81, 3'd4, 1'b0, 8'h81, 3'd1, 1'b0, 1'b1, 1'b0};
        vecs[16] = '{8'h00, 3'd4, 1'b0, 8'h81, 3'd7, 1'b1, 1'b1, 1'b0};

        step();
        check("reset_req", 32'(bus.req_pending), 32'h00);
        check("reset_valid", 32'(bus.target_valid), 32'h0);
        check("reset_dir", 32'(bus.dir_up), 32'h1);
        check("reset_idle", 32'(bus.idle), 32'h1);
        reset = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].btn, vecs[i].cur, vecs[i].arr);
            step();
            check($sformatf("v%0d_req", i), 32'(bus.req_pending), 32'(vecs[i].req));
            check($sformatf("v%0d_tgt", i), 32'(bus.target_floor), 32'(vecs[i].tgt));
            check($sformatf("v%0d_vld", i), 32'(bus.target_valid), 32'(vecs[i].vld));
            check($sformatf("v%0d_dir", i), 32'(bus.dir_up), 32'(vecs[i].dir));
            check($sformatf("v%0d_idle", i), 32'(bus.idle), 32'(vecs[i].idl));
        end

        // Buttons held through reset release latch exactly once.
        drive(8'hFF, 3'd3, 1'b0);
        do_reset();
        repeat (10) step();
        check("held_req", 32'(bus.req_pending), 32'hFF);
        check("held_idle", 32'(bus.idle), 32'h0);
        check("held_tgt_here", 32'(bus.target_floor), 32'd3);
        check("held_vld", 32'(bus.target_valid), 32'h1);
        drive(8'hFF, 3'd3, 1'b1);
        step();
        check("held_arrive_clr", 32'(bus.req_pending), 32'hF7);
        drive(8'hFF, 3'd3, 1'b0);
        repeat (3) step();
        check("held_no_reset", 32'(bus.req_pending), 32'hF7);
        check("held_next_tgt", 32'(bus.target_floor), 32'd4);
        check("held_state_up", 32'(bus.state_dbg), 32'd1);

        // Call ahead of the car in SCAN_UP retargets to the nearer floor.
        drive(8'h00, 3'd3, 1'b0);
        do_reset();
        drive(8'h40, 3'd3, 1'b0);
        step();
        drive(8'h00, 3'd3, 1'b0);
        step();
        check("retgt_first", 32'(bus.target_floor), 32'd6);
        check("retgt_first_vld", 32'(bus.target_valid), 32'h1);
        drive(8'h10, 3'd3, 1'b0);
        step();
        check("retgt_lag", 32'(bus.target_floor), 32'd6);
        drive(8'h00, 3'd3, 1'b0);
        step();
        check("retgt_near", 32'(bus.target_floor), 32'd4);
        drive(8'h00, 3'd4, 1'b1);
        step();
        check("retgt_arr_req", 32'(bus.req_pending), 32'h40);
        check("retgt_back", 32'(bus.target_floor), 32'd6);
        drive(8'h00, 3'd4, 1'b0);

        // Async reset in SCAN_DOWN takes effect before the next clock edge.
        drive(8'h00, 3'd7, 1'b0);
        do_reset();
        drive(8'h29, 3'd7, 1'b0);
        step();
        drive(8'h00, 3'd7, 1'b0);
        step();
        check("down_state", 32'(bus.state_dbg), 32'd2);
        check("down_dir", 32'(bus.dir_up), 32'h0);
        check("down_tgt", 32'(bus.target_floor), 32'd5);
        check("down_req", 32'(bus.req_pending), 32'h29);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("async_req", 32'(bus.req_pending), 32'h00);
        check("async_tgt", 32'(bus.target_floor), 32'd0);
        check("async_vld", 32'(bus.target_valid), 32'h0);
        check("async_dir", 32'(bus.dir_up), 32'h1);
        check("async_idle", 32'(bus.idle), 32'h1);
        check("async_state", 32'(bus.state_dbg), 32'd0);
        step();
        reset = 1'b1;
        step();
        check("post_reset_req", 32'(bus.req_pending), 32'h00);
        check("post_reset_idle", 32'(bus.idle), 32'h1);

        // final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
